// File: rtl/deint_pkg.sv
// Shared constants and helpers for the block deinterleaver.
// The optional misaligned-sof counter is enabled with DEINT_SOF_ERR_EN.
package deint_pkg;
  localparam int DEINT_ROWS_DEF = 4;
  localparam int DEINT_COLS_DEF = 4;
  localparam int DEINT_ERR_W    = 8;

  // Width of an index into an N-entry block; never narrower than one bit.
  function automatic int deint_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/deint_addr_gen.sv
// Row/column counters that turn the running write index n into the
// de-permuted read address col*ROWS + row, avoiding divide/mod hardware.
module deint_addr_gen
  import deint_pkg::*;
#(
  parameter int ROWS = DEINT_ROWS_DEF,
  parameter int COLS = DEINT_COLS_DEF,
  localparam int IW  = deint_idx_w(ROWS * COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  input  logic          restart,
  output logic [IW-1:0] raddr
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;

  // restart treats the current beat as index 0, so the counters land on index 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (restart) begin
      col_reg <= CW'(1);
      row_reg <= '0;
    end else if (advance) begin
      if (col_reg == CW'(COLS - 1)) begin
        col_reg <= '0;
        if (row_reg == RW'(ROWS - 1)) row_reg <= '0;
        else                          row_reg <= row_reg + RW'(1);
      end else begin
        col_reg <= col_reg + CW'(1);
      end
    end
  end

  assign raddr = IW'(32'(col_reg) * ROWS + 32'(row_reg));
endmodule

// File: rtl/deinterleaver.sv
// Ping-pong row/column block deinterleaver: one bank fills while the other
// is read in de-permuted order. Define DEINT_SOF_ERR_EN to add err_cnt_o.
module deinterleaver
  import deint_pkg::*;
#(
  parameter int  ROWS = DEINT_ROWS_DEF,
  parameter int  COLS = DEINT_COLS_DEF,
  localparam int N    = ROWS * COLS,
  localparam int IW   = deint_idx_w(N)
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  logic sof_i,
  input  logic data_i,
  output logic valid_o,
  output logic sof_o,
  output logic data_o
`ifdef DEINT_SOF_ERR_EN
  ,
  output logic [DEINT_ERR_W-1:0] err_cnt_o
`endif
);
  logic          bank_mem [2][N];
  logic [IW-1:0] wr_idx_reg;
  logic          wr_bank_reg;
  logic [1:0]    bank_full_reg;
  logic [IW-1:0] raddr;
  logic          rd_bank;
  logic          misalign;
  logic          wrap;

  assign rd_bank  = ~wr_bank_reg;
  assign misalign = valid_i && sof_i && (wr_idx_reg != '0);
  assign wrap     = valid_i && !misalign && (wr_idx_reg == IW'(N - 1));

  deint_addr_gen #(.ROWS(ROWS), .COLS(COLS)) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .advance(valid_i),
    .restart(misalign),
    .raddr  (raddr)
  );

  // Storage carries no reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (valid_i) begin
      bank_mem[wr_bank_reg][misalign ? '0 : wr_idx_reg] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx_reg    <= '0;
      wr_bank_reg   <= 1'b0;
      bank_full_reg <= 2'b00;
      valid_o       <= 1'b0;
      sof_o         <= 1'b0;
      data_o        <= 1'b0;
    end else if (!valid_i) begin
      valid_o <= 1'b0;
      sof_o   <= 1'b0;
    end else if (misalign) begin
      // Resync: drop the partial block and anything waiting to be read.
      wr_idx_reg    <= IW'(1);
      bank_full_reg <= 2'b00;
      valid_o       <= 1'b0;
      sof_o         <= 1'b0;
    end else begin
      if (bank_full_reg[rd_bank]) begin
        data_o  <= bank_mem[rd_bank][raddr];
        valid_o <= 1'b1;
        sof_o   <= (wr_idx_reg == '0);
      end else begin
        valid_o <= 1'b0;
        sof_o   <= 1'b0;
      end
      if (wrap) begin
        wr_idx_reg                 <= '0;
        wr_bank_reg                <= rd_bank;
        bank_full_reg[wr_bank_reg] <= 1'b1;
        bank_full_reg[rd_bank]     <= 1'b0;
      end else begin
        wr_idx_reg <= wr_idx_reg + IW'(1);
      end
    end
  end

`ifdef DEINT_SOF_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_o <= '0;
    end else if (misalign && (err_cnt_o != '1)) begin
      err_cnt_o <= err_cnt_o + DEINT_ERR_W'(1);
    end
  end
`endif
endmodule
